data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 59 +++++
 tb/tb_data_memory.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : Word-addressed data memory with a combinational read, a
//               synchronous write and an asynchronous clear of every word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  WE_dmem,
  input  logic [DATA_WIDTH-1:0] reg_out,
  input  logic [15:0]           alu_out,
  output logic [DATA_WIDTH-1:0] mem_out
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_in_range;

  assign w_idx = alu_out[ADDR_WIDTH-1:0];

  // Any set bit above the implemented range makes the access a no-op, so
  // high addresses never alias onto the low words.
  generate
    if (ADDR_WIDTH < 16) begin : g_range_check
      assign w_in_range = (alu_out[15:ADDR_WIDTH] == '0);
    end else begin : g_range_full
      assign w_in_range = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (WE_dmem && w_in_range) begin
      r_mem[w_idx] <= reg_out;
    end
  end

  // The rst_n gate keeps the output clean even before the clear settles.
  always_comb begin
    mem_out = '0;
    if (rst_n && w_in_range) begin
      mem_out = r_mem[w_idx];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// Module      : tb_data_memory
// Description : Directed self-checking bench for data_memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        WE_dmem;
  logic [15:0] reg_out;
  logic [15:0] alu_out;
  logic [15:0] mem_out;

  int checks   = 0;
  int failures = 0;

  data_memory #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .WE_dmem(WE_dmem),
    .reg_out(reg_out),
    .alu_out(alu_out),
    .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_word(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    WE_dmem = 1'b1;
    alu_out = addr;
    reg_out = data;
    @(posedge clk);
    #1;
    WE_dmem = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      alu_out = a[15:0];
      #1;
      checks++;
      if (mem_out !== 16'h0000) begin
        failures++;
        bad++;
        if (bad <= 4)
          $display("FAIL reset_sweep addr=%0d got=%h expected=0000", a, mem_out);
      end
    end
  endtask

  task automatic test_write_read();
    write_word(16'd5, 16'hBEEF);
    alu_out = 16'd5;
    #1;
    checks++;
    if (mem_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_read addr=5 got=%h expected=BEEF", mem_out);
    end
    alu_out = 16'd6;
    #1;
    checks++;
    if (mem_out !== 16'h0000) begin
      failures++;
      $display("FAIL write_read addr=6 got=%h expected=0000", mem_out);
    end
  endtask

  task automatic test_no_write_enable();
    @(negedge clk);
    WE_dmem = 1'b0;
    alu_out = 16'd5;
    reg_out = 16'h1234;
    @(posedge clk);
    #1;
    checks++;
    if (mem_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL no_we addr=5 got=%h expected=BEEF", mem_out);
    end
  endtask

  task automatic test_out_of_range();
    write_word(16'h0105, 16'hAAAA);
    alu_out = 16'h0105;
    #1;
    checks++;
    if (mem_out !== 16'h0000) begin
      failures++;
      $display("FAIL oor_read addr=0105 got=%h expected=0000", mem_out);
    end
    alu_out = 16'd5;
    #1;
    checks++;
    if (mem_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL oor_alias addr=5 got=%h expected=BEEF", mem_out);
    end
    alu_out = 16'h8005;
    #1;
    checks++;
    if (mem_out !== 16'h0000) begin
      failures++;
      $display("FAIL oor_high addr=8005 got=%h expected=0000", mem_out);
    end
  endtask

  task automatic test_boundaries();
    write_word(16'd0, 16'hFFFF);
    alu_out = 16'd0;
    #1;
    checks++;
    if (mem_out !== 16'hFFFF) begin
      failures++;
      $display("FAIL addr0_first got=%h expected=FFFF", mem_out);
    end
    write_word(16'd255, 16'h8001);
    write_word(16'd0, 16'h0001);
    alu_out = 16'd0;
    #1;
    checks++;
    if (mem_out !== 16'h0001) begin
      failures++;
      $display("FAIL addr0_overwrite got=%h expected=0001", mem_out);
    end
    alu_out = 16'd255;
    #1;
    checks++;
    if (mem_out !== 16'h8001) begin
      failures++;
      $display("FAIL addr255 got=%h expected=8001", mem_out);
    end
    alu_out = 16'd1;
    #1;
    checks++;
    if (mem_out !== 16'h0000) begin
      failures++;
      $display("FAIL addr1_undisturbed got=%h expected=0000", mem_out);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    WE_dmem = 1'b1;
    alu_out = 16'd7;
    reg_out = 16'h9999;
    #1;
    checks++;
    if (mem_out !== 16'h0000) begin
      failures++;
      $display("FAIL rdw_before got=%h expected=0000", mem_out);
    end
    @(posedge clk);
    #1;
    WE_dmem = 1'b0;
    checks++;
    if (mem_out !== 16'h9999) begin
      failures++;
      $display("FAIL rdw_after got=%h expected=9999", mem_out);
    end
    alu_out = 16'd8;
    #1;
    checks++;
    if (mem_out !== 16'h0000) begin
      failures++;
      $display("FAIL rdw_neighbour got=%h expected=0000", mem_out);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] probe [4];
    probe[0] = 16'd0;
    probe[1] = 16'd5;
    probe[2] = 16'd7;
    probe[3] = 16'd255;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      alu_out = probe[k];
      #0.5;
      checks++;
      if (mem_out !== 16'h0000) begin
        failures++;
        $display("FAIL midreset_clear addr=%0d got=%h expected=0000", probe[k], mem_out);
      end
    end
    WE_dmem = 1'b1;
    alu_out = 16'd3;
    reg_out = 16'h5A5A;
    @(posedge clk);
    #1;
    checks++;
    if (mem_out !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_blocked addr=3 got=%h expected=0000", mem_out);
    end
    @(negedge clk);
    WE_dmem = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_out !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_released addr=3 got=%h expected=0000", mem_out);
    end
    // First edge after release must already accept a write.
    WE_dmem = 1'b1;
    reg_out = 16'h1111;
    @(posedge clk);
    #1;
    WE_dmem = 1'b0;
    checks++;
    if (mem_out !== 16'h1111) begin
      failures++;
      $display("FAIL first_write_after_reset got=%h expected=1111", mem_out);
    end
    alu_out = 16'd255;
    #1;
    checks++;
    if (mem_out !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_addr255 got=%h expected=0000", mem_out);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    WE_dmem = 1'b0;
    reg_out = 16'h0000;
    alu_out = 16'h0000;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_write_read();
    test_no_write_enable();
    test_out_of_range();
    test_boundaries();
    test_read_during_write();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
